// File: rtl/scanner_pkg.sv
// Shared types and helpers for the LED-matrix row scanner.
package scanner_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    // Registered single-bit panel/filler controls, grouped so they reset and hold together.
    typedef struct packed {
        logic lat;
        logic oe_n;
        logic fill_en;
        logic frame_start;
        logic fill_timeout;
    } scan_pins_t;

    localparam scan_pins_t PINS_RESET = '{
        lat:          1'b0,
        oe_n:         1'b1,
        fill_en:      1'b0,
        frame_start:  1'b0,
        fill_timeout: 1'b0
    };

    // Twice the nominal fill time: a healthy filler needs COLS shifts of SHIFT_DIV clocks.
    function automatic int fill_timeout_cycles(input int cols, input int shift_div);
        return 2 * cols * shift_div;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/matrix_row_scanner_strobe_divider.sv
// Periodic one-clock strobe. clear/enable describe the upcoming cycle, so tick lands
// on enabled cycles DIV-1, 2*DIV-1, ... counted from the cycle after clear.
module strobe_divider #(
    parameter int DIV = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int DIV_W = $clog2(DIV) + 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (enable && !clear) begin
            div_d  = (div_q == LAST) ? '0 : div_q + DIV_W'(1);
            tick_d = (div_d == LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/matrix_row_scanner.sv
// Row sequencer for the dual-half RGB LED matrix: fill, blank, latch, display per row pair.
module matrix_row_scanner
    import scanner_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int ADDR_W         = 4,
    parameter int COLS           = 32,
    parameter int SHIFT_DIV      = 33,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              fill_done,
    output logic              fill_en,
    output logic              shift_tick,
    output logic [ADDR_W-1:0] row_addr,
    output logic              lat,
    output logic              oe_n,
    output logic              frame_start,
    output logic              fill_timeout
);

    localparam int FILL_TIMEOUT = fill_timeout_cycles(COLS, SHIFT_DIV);
    localparam int MAX_COUNT    = max3(FILL_TIMEOUT, LATCH_CYCLES, DISPLAY_CYCLES);
    localparam int CNT_W        = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0]  FILL_LAST    = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DISPLAY_LAST = CNT_W'(DISPLAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW     = ADDR_W'(ROWS - 1);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] load_row_q, load_row_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    scan_pins_t        pins_q, pins_d;

    logic [ADDR_W-1:0] row_next;
    logic              fill_seen;
    logic              fill_expired;
    logic              div_clear;
    logic              div_enable;

    assign row_next     = (load_row_q == LAST_ROW) ? '0 : load_row_q + ADDR_W'(1);
    // The filler's flag may still be high from the previous row on the first FILL cycle.
    assign fill_seen    = fill_done && (cnt_q != '0);
    assign fill_expired = (cnt_q == FILL_LAST);

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        load_row_d         = load_row_q;
        row_addr_d         = row_addr_q;
        pins_d             = pins_q;
        pins_d.frame_start = 1'b0;
        div_clear          = 1'b0;

        case (state_q)
            IDLE: begin
                pins_d.oe_n    = 1'b1;
                pins_d.fill_en = 1'b0;
                if (run) begin
                    state_d            = FILL;
                    cnt_d              = '0;
                    load_row_d         = '0;
                    pins_d.fill_en     = 1'b1;
                    pins_d.frame_start = 1'b1;
                    div_clear          = 1'b1;
                end
            end

            FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fill_seen || fill_expired) begin
                    state_d        = BLANK;
                    cnt_d          = '0;
                    pins_d.fill_en = 1'b0;
                    pins_d.oe_n    = 1'b1;
                    if (!fill_seen) begin
                        pins_d.fill_timeout = 1'b1;
                    end
                end
            end

            BLANK: begin
                state_d    = LATCH;
                cnt_d      = '0;
                row_addr_d = load_row_q;
                pins_d.lat = 1'b1;
            end

            LATCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LATCH_LAST) begin
                    state_d     = DISPLAY;
                    cnt_d       = '0;
                    pins_d.lat  = 1'b0;
                    pins_d.oe_n = 1'b0;
                end
            end

            DISPLAY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DISPLAY_LAST) begin
                    cnt_d      = '0;
                    load_row_d = row_next;
                    if (run) begin
                        // Current row stays lit while the next one shifts in.
                        state_d            = FILL;
                        pins_d.fill_en     = 1'b1;
                        pins_d.frame_start = (row_next == '0);
                        div_clear          = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        pins_d.oe_n = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pins_d  = PINS_RESET;
            end
        endcase
    end

    assign div_enable = (state_d == FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            load_row_q <= '0;
            row_addr_q <= '0;
            pins_q     <= PINS_RESET;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            load_row_q <= load_row_d;
            row_addr_q <= row_addr_d;
            pins_q     <= pins_d;
        end
    end

    strobe_divider #(
        .DIV (SHIFT_DIV)
    ) u_shift_div (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .enable (div_enable),
        .tick   (shift_tick)
    );

    assign fill_en      = pins_q.fill_en;
    assign row_addr     = row_addr_q;
    assign lat          = pins_q.lat;
    assign oe_n         = pins_q.oe_n;
    assign frame_start  = pins_q.frame_start;
    assign fill_timeout = pins_q.fill_timeout;

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Bench for matrix_row_scanner: a per-row timeline model builds stimulus and expected pins.
module tb_matrix_row_scanner;

    localparam int ROWS           = 4;
    localparam int ADDR_W         = 4;
    localparam int COLS           = 4;
    localparam int SHIFT_DIV      = 4;
    localparam int LATCH_CYCLES   = 2;
    localparam int DISPLAY_CYCLES = 10;
    localparam int FILL_TIMEOUT   = 2 * COLS * SHIFT_DIV;

    typedef struct packed {
        logic reset;
        logic run;
        logic fill_done;
    } stim_t;

    typedef struct packed {
        logic              fill_en;
        logic              shift_tick;
        logic [ADDR_W-1:0] row_addr;
        logic              lat;
        logic              oe_n;
        logic              frame_start;
        logic              fill_timeout;
    } pins_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic              fill_done;
    logic              fill_en;
    logic              shift_tick;
    logic [ADDR_W-1:0] row_addr;
    logic              lat;
    logic              oe_n;
    logic              frame_start;
    logic              fill_timeout;

    int errors = 0;
    int checks = 0;

    stim_t stim_q[$];
    pins_t exp_q[$];

    int cur_addr  = 0;
    int next_row  = 0;
    bit lit       = 1'b0;
    bit sticky_to = 1'b0;

    always #5 clk = ~clk;

    matrix_row_scanner #(
        .ROWS           (ROWS),
        .ADDR_W         (ADDR_W),
        .COLS           (COLS),
        .SHIFT_DIV      (SHIFT_DIV),
        .LATCH_CYCLES   (LATCH_CYCLES),
        .DISPLAY_CYCLES (DISPLAY_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .fill_done    (fill_done),
        .fill_en      (fill_en),
        .shift_tick   (shift_tick),
        .row_addr     (row_addr),
        .lat          (lat),
        .oe_n         (oe_n),
        .frame_start  (frame_start),
        .fill_timeout (fill_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    function automatic bit rnd();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic pins_t mk(bit fe, bit st, int addr, bit l, bit oe, bit fs);
        pins_t p;
        p.fill_en      = fe;
        p.shift_tick   = st;
        p.row_addr     = addr[ADDR_W-1:0];
        p.lat          = l;
        p.oe_n         = oe;
        p.frame_start  = fs;
        p.fill_timeout = sticky_to;
        return p;
    endfunction

    task automatic push(input bit rst, input bit r, input bit fd, input pins_t e);
        stim_t s;
        s.reset     = rst;
        s.run       = r;
        s.fill_done = fd;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Idle stretch; when start is set, run rises on its last cycle so FILL follows.
    task automatic idle_seg(input int len, input bit start, input bit hold_done);
        for (int i = 0; i < len; i++) begin
            push(1'b0, start && (i == len - 1), hold_done ? 1'b1 : rnd(),
                 mk(1'b0, 1'b0, cur_addr, 1'b0, 1'b1, 1'b0));
        end
        next_row = 0;
        lit      = 1'b0;
    endtask

    // One row: done_at is the FILL cycle where fill_done is seen (0 = never, timeout).
    // reset_at >= 0 pulses reset on that DISPLAY cycle instead of finishing the row.
    task automatic row_seg(input int done_at, input bit cont, input int reset_at);
        int fill_len;
        bit fd;
        fill_len = (done_at != 0) ? done_at + 1 : FILL_TIMEOUT;
        for (int j = 0; j < fill_len; j++) begin
            fd = (j == 0) ? rnd() : (done_at != 0 && j == done_at);
            push(1'b0, rnd(), fd,
                 mk(1'b1, ((j + 1) % SHIFT_DIV) == 0, cur_addr, 1'b0, !lit,
                    (j == 0) && (next_row == 0)));
        end
        if (done_at == 0) sticky_to = 1'b1;
        push(1'b0, rnd(), rnd(), mk(1'b0, 1'b0, cur_addr, 1'b0, 1'b1, 1'b0));
        cur_addr = next_row;
        for (int i = 0; i < LATCH_CYCLES; i++) begin
            push(1'b0, rnd(), rnd(), mk(1'b0, 1'b0, cur_addr, 1'b1, 1'b1, 1'b0));
        end
        for (int i = 0; i < DISPLAY_CYCLES; i++) begin
            if (i == reset_at) begin
                push(1'b1, rnd(), rnd(), mk(1'b0, 1'b0, cur_addr, 1'b0, 1'b0, 1'b0));
                cur_addr  = 0;
                next_row  = 0;
                lit       = 1'b0;
                sticky_to = 1'b0;
                return;
            end
            push(1'b0, (i == DISPLAY_CYCLES - 1) ? cont : rnd(), rnd(),
                 mk(1'b0, 1'b0, cur_addr, 1'b0, 1'b0, 1'b0));
        end
        next_row = (next_row + 1) % ROWS;
        lit      = cont;
    endtask

    task automatic build();
        int done_at;
        int reset_at;
        bit cont;
        idle_seg(21, 1'b1, 1'b0);
        row_seg(4 * SHIFT_DIV, 1'b1, -1);
        row_seg(0, 1'b1, -1);
        row_seg(5, 1'b0, -1);
        idle_seg(5, 1'b1, 1'b0);
        row_seg(9, 1'b1, -1);
        row_seg(0, 1'b1, 4);
        idle_seg(8, 1'b1, 1'b1);
        for (int r = 0; r <= ROWS; r++) begin
            row_seg($urandom_range(1, FILL_TIMEOUT - 1), 1'b1, -1);
        end
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       done_at = 0;
                1:       done_at = 1;
                2:       done_at = FILL_TIMEOUT - 1;
                default: done_at = $urandom_range(2, FILL_TIMEOUT - 2);
            endcase
            cont     = ($urandom_range(0, 9) != 0);
            reset_at = ($urandom_range(0, 14) == 0) ? $urandom_range(0, DISPLAY_CYCLES - 1) : -1;
            row_seg(done_at, cont, reset_at);
            if (reset_at >= 0 || !cont) idle_seg($urandom_range(1, 6), 1'b1, rnd());
        end
        row_seg(3, 1'b0, -1);
        idle_seg(6, 1'b0, 1'b1);
    endtask

    initial begin
        pins_t got;
        reset     = 1'b1;
        run       = 1'b0;
        fill_done = 1'b0;
        build();
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < exp_q.size(); n++) begin
            reset     = stim_q[n].reset;
            run       = stim_q[n].run;
            fill_done = stim_q[n].fill_done;
            @(negedge clk);
            got = {fill_en, shift_tick, row_addr, lat, oe_n, frame_start, fill_timeout};
            check($sformatf("cycle%0d", n), 32'(got), 32'(exp_q[n]));
            @(posedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
